// File: rtl/snoop_bus_pkg.sv
// Shared types and constants for the snooping bus interconnect.
package snoop_bus_pkg;

  localparam int MAX_CORES = 8;

  // MSI bus operations as driven by the L1 caches; BUS_NON marks an idle lane.
  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_UPGR = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_NON  = 2'b11
  } bus_op_t;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    SNOOP,
    MEM,
    RELEASE
  } ic_state_t;

  // Operations that need line data from memory when no cache flushes it.
  function automatic logic needs_mem_read(bus_op_t op);
    return (op == BUS_RD) || (op == BUS_RDX);
  endfunction

endpackage

// File: rtl/snoop_bus_interconnect_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester strictly after ptr wins.
module rr_arbiter
  import snoop_bus_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  int idx;

  // Scan cyclically from ptr+1 and stop at the first active request.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_interconnect.sv
// N-core snooping bus: round-robin grant, MSI broadcast, snoop collection,
// cache-to-cache flush forwarding and memory read/write-back.
//
// state   | meaning
// IDLE    | no owner, arbitrating pending requests
// GRANT   | owner granted, waiting for its bus operation
// SNOOP   | operation broadcast, collecting hits/flushes from other cores
// MEM     | memory read or write-back outstanding, waiting for mem_ack
// RELEASE | transaction done, waiting for the owner to drop its request
module snoop_bus_interconnect
  import snoop_bus_pkg::*;
#(
  parameter int NUM_CORES    = 2,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int SNOOP_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req_core,
  output logic [NUM_CORES-1:0]        grant,
  input  logic [2*NUM_CORES-1:0]      core_op,
  input  logic [ADDR_W*NUM_CORES-1:0] core_addr,
  input  logic [DATA_W*NUM_CORES-1:0] core_data,
  input  logic [NUM_CORES-1:0]        core_hit,
  input  logic [NUM_CORES-1:0]        core_flush,
  output logic [1:0]                  bus_operation_in,
  output logic [ADDR_W-1:0]           bus_address_in,
  output logic [DATA_W-1:0]           bus_data_in,
  output logic [NUM_CORES-1:0]        cache_hit_in,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ack
);

  localparam int IDX_W = $clog2(NUM_CORES);
  localparam int CNT_W = 2;

  ic_state_t             state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  bus_op_t               op_q, op_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [CNT_W-1:0]      snoop_cnt_q, snoop_cnt_d;
  logic                  hit_acc_q, hit_acc_d;
  logic                  flush_seen_q, flush_seen_d;
  logic [DATA_W-1:0]     flush_data_q, flush_data_d;

  logic [NUM_CORES-1:0]  grant_q, grant_d;
  bus_op_t               bus_op_q, bus_op_d;
  logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]     bus_data_q, bus_data_d;
  logic [NUM_CORES-1:0]  cache_hit_q, cache_hit_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

  logic [NUM_CORES-1:0]  arb_gnt;
  logic                  arb_valid;
  logic [IDX_W-1:0]      arb_idx;

  bus_op_t               owner_op;
  logic [ADDR_W-1:0]     owner_addr;
  logic [DATA_W-1:0]     owner_data;
  logic [NUM_CORES-1:0]  others_hit;
  logic [NUM_CORES-1:0]  others_flush;
  logic [DATA_W-1:0]     flush_pick;
  logic                  flush_found;
  logic                  hit_now;
  logic                  flush_now;
  logic [DATA_W-1:0]     flush_data_now;

  rr_arbiter #(.N(NUM_CORES), .PTR_W(IDX_W)) u_arb (
    .req   (req_core),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  assign owner_op     = bus_op_t'(core_op[int'(owner_q)*2 +: 2]);
  assign owner_addr   = core_addr[int'(owner_q)*ADDR_W +: ADDR_W];
  assign owner_data   = core_data[int'(owner_q)*DATA_W +: DATA_W];
  assign others_hit   = core_hit & ~grant_q;
  assign others_flush = core_flush & ~grant_q;

  // Encode the one-hot arbiter winner into an owner index.
  always_comb begin
    arb_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (arb_gnt[k]) arb_idx = IDX_W'(k);
    end
  end

  // Lowest-index non-owner flusher in the current cycle supplies the line.
  always_comb begin
    flush_pick  = '0;
    flush_found = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (others_flush[k] && !flush_found) begin
        flush_pick  = core_data[k*DATA_W +: DATA_W];
        flush_found = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic; everything holds unless a state moves it.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    op_d           = op_q;
    addr_d         = addr_q;
    data_d         = data_q;
    snoop_cnt_d    = snoop_cnt_q;
    hit_acc_d      = hit_acc_q;
    flush_seen_d   = flush_seen_q;
    flush_data_d   = flush_data_q;
    grant_d        = grant_q;
    bus_op_d       = bus_op_q;
    bus_addr_d     = bus_addr_q;
    bus_data_d     = bus_data_q;
    cache_hit_d    = cache_hit_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    hit_now        = hit_acc_q | (|others_hit);
    flush_now      = flush_seen_q | (|others_flush);
    flush_data_now = flush_seen_q ? flush_data_q : flush_pick;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_gnt;
          owner_d = arb_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (owner_op != BUS_NON) begin
          op_d         = owner_op;
          addr_d       = owner_addr;
          data_d       = owner_data;
          bus_op_d     = owner_op;
          bus_addr_d   = owner_addr;
          snoop_cnt_d  = CNT_W'(SNOOP_CYCLES - 1);
          hit_acc_d    = 1'b0;
          flush_seen_d = 1'b0;
          state_d      = SNOOP;
        end else if (!req_core[owner_q]) begin
          state_d = RELEASE;
        end
      end
      SNOOP: begin
        bus_op_d    = BUS_NON;
        hit_acc_d   = hit_now;
        cache_hit_d = hit_now ? grant_q : '0;
        if (!flush_seen_q && (|others_flush)) begin
          flush_seen_d = 1'b1;
          flush_data_d = flush_pick;
        end
        if (snoop_cnt_q == '0) begin
          if (flush_now) begin
            bus_data_d  = flush_data_now;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = flush_data_now;
            state_d     = MEM;
          end else if (needs_mem_read(op_q)) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = addr_q;
            mem_wdata_d = data_q;
            state_d     = MEM;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          snoop_cnt_d = snoop_cnt_q - 1'b1;
        end
      end
      MEM: begin
        if (mem_ack) begin
          if (!mem_we_q) bus_data_d = mem_rdata;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (!req_core[owner_q]) begin
          grant_d     = '0;
          rr_ptr_d    = owner_q;
          cache_hit_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= IDX_W'(NUM_CORES - 1);
      op_q         <= BUS_NON;
      addr_q       <= '0;
      data_q       <= '0;
      snoop_cnt_q  <= '0;
      hit_acc_q    <= 1'b0;
      flush_seen_q <= 1'b0;
      flush_data_q <= '0;
      grant_q      <= '0;
      bus_op_q     <= BUS_NON;
      bus_addr_q   <= '0;
      bus_data_q   <= '0;
      cache_hit_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      snoop_cnt_q  <= snoop_cnt_d;
      hit_acc_q    <= hit_acc_d;
      flush_seen_q <= flush_seen_d;
      flush_data_q <= flush_data_d;
      grant_q      <= grant_d;
      bus_op_q     <= bus_op_d;
      bus_addr_q   <= bus_addr_d;
      bus_data_q   <= bus_data_d;
      cache_hit_q  <= cache_hit_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign grant            = grant_q;
  assign bus_operation_in = bus_op_q;
  assign bus_address_in   = bus_addr_q;
  assign bus_data_in      = bus_data_q;
  assign cache_hit_in     = cache_hit_q;
  assign mem_req          = mem_req_q;
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;

endmodule

// File: tb/tb_snoop_bus_interconnect.sv
// Directed bench: a 4-core bus (single snoop cycle) and a 2-core bus with a
// three-cycle snoop window, driven as the cores and the memory would.
module tb_snoop_bus_interconnect;
  import snoop_bus_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // 4-core instance
  logic [3:0]   req_a = '0;
  logic [3:0]   grant_a;
  logic [7:0]   core_op_a = '1;
  logic [127:0] core_addr_a = '0;
  logic [127:0] core_data_a = '0;
  logic [3:0]   hit_a = '0;
  logic [3:0]   flush_a = '0;
  logic [1:0]   bus_op_a;
  logic [31:0]  bus_addr_a;
  logic [31:0]  bus_data_a;
  logic [3:0]   cache_hit_a;
  logic         mem_req_a;
  logic         mem_we_a;
  logic [31:0]  mem_addr_a;
  logic [31:0]  mem_wdata_a;
  logic [31:0]  mem_rdata_a = '0;
  logic         mem_ack_a = 1'b0;

  snoop_bus_interconnect #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32), .SNOOP_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .req_core(req_a), .grant(grant_a),
    .core_op(core_op_a), .core_addr(core_addr_a), .core_data(core_data_a),
    .core_hit(hit_a), .core_flush(flush_a),
    .bus_operation_in(bus_op_a), .bus_address_in(bus_addr_a), .bus_data_in(bus_data_a),
    .cache_hit_in(cache_hit_a), .mem_req(mem_req_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .mem_ack(mem_ack_a)
  );

  // 2-core instance with a 3-cycle snoop window
  logic [1:0]  req_b = '0;
  logic [1:0]  grant_b;
  logic [3:0]  core_op_b = '1;
  logic [63:0] core_addr_b = '0;
  logic [63:0] core_data_b = '0;
  logic [1:0]  hit_b = '0;
  logic [1:0]  flush_b = '0;
  logic [1:0]  bus_op_b;
  logic [31:0] bus_addr_b;
  logic [31:0] bus_data_b;
  logic [1:0]  cache_hit_b;
  logic        mem_req_b;
  logic        mem_we_b;
  logic [31:0] mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic [31:0] mem_rdata_b = '0;
  logic        mem_ack_b = 1'b0;

  snoop_bus_interconnect #(.NUM_CORES(2), .ADDR_W(32), .DATA_W(32), .SNOOP_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .req_core(req_b), .grant(grant_b),
    .core_op(core_op_b), .core_addr(core_addr_b), .core_data(core_data_b),
    .core_hit(hit_b), .core_flush(flush_b),
    .bus_operation_in(bus_op_b), .bus_address_in(bus_addr_b), .bus_data_in(bus_data_b),
    .cache_hit_in(cache_hit_b), .mem_req(mem_req_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .mem_ack(mem_ack_b)
  );

  typedef struct {
    int          owner;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [3:0]  hit;
    logic [3:0]  flush;
    logic [127:0] snoop_data;   // {core3, core2, core1, core0}
    logic [31:0] rdata;
    logic        exp_mem;
    logic        exp_we;
    logic [31:0] exp_data;
    logic [3:0]  exp_cache_hit;
  } vec_t;

  vec_t vecs[5];
  logic [3:0] rr_exp[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  // One complete transaction on the 4-core bus with a single requester.
  task automatic run_vec(input vec_t v);
    logic [3:0] own;
    own = 4'b0001 << v.owner;
    req_a = own;
    tick();
    check("grant", grant_a, own);
    core_op_a[v.owner*2 +: 2]    = v.op;
    core_addr_a[v.owner*32 +: 32] = v.addr;
    core_data_a[v.owner*32 +: 32] = 32'h5555_0000;
    tick();
    check("bcast_op", bus_op_a, v.op);
    check("bcast_addr", bus_addr_a, v.addr);
    core_op_a   = '1;
    hit_a       = v.hit;
    flush_a     = v.flush;
    core_data_a = v.snoop_data;
    tick();
    hit_a   = '0;
    flush_a = '0;
    check("op_idle", bus_op_a, 2'b11);
    check("cache_hit", cache_hit_a, v.exp_cache_hit);
    check("mem_req", mem_req_a, v.exp_mem);
    if (v.exp_mem) begin
      check("mem_we", mem_we_a, v.exp_we);
      check("mem_addr", mem_addr_a, v.addr);
      if (v.exp_we) begin
        check("mem_wdata", mem_wdata_a, v.exp_data);
        check("flush_data", bus_data_a, v.exp_data);
      end
      tick();
      check("mem_hold", mem_req_a, 1'b1);
      mem_ack_a   = 1'b1;
      mem_rdata_a = v.rdata;
      tick();
      mem_ack_a   = 1'b0;
      mem_rdata_a = '0;
      check("mem_done", mem_req_a, 1'b0);
      check("bus_data", bus_data_a, v.exp_data);
    end
    check("grant_held", grant_a, own);
    req_a = '0;
    tick();
    check("grant_off", grant_a, 4'b0000);
    check("hit_clear", cache_hit_a, 4'b0000);
    tick();
  endtask

  initial begin
    //            owner op     addr      hit      flush    snoop data {c3,c2,c1,c0}                            rdata          mem   we    exp data      exp hit
    vecs[0] = '{2, 2'b00, 32'h40,  4'b0000, 4'b0000, 128'h0,                                               32'h0000_DEAD, 1'b1, 1'b0, 32'h0000_DEAD, 4'b0000};
    vecs[1] = '{0, 2'b10, 32'h80,  4'b0010, 4'b1010, {32'h33, 32'h0, 32'h11, 32'h0},                       32'hFFFF_FFFF, 1'b1, 1'b1, 32'h11,        4'b0001};
    vecs[2] = '{1, 2'b01, 32'h100, 4'b0101, 4'b0000, 128'h0,                                               32'h0,         1'b0, 1'b0, 32'h0,         4'b0010};
    vecs[3] = '{3, 2'b00, 32'hC0,  4'b1000, 4'b1000, {32'h77, 32'h0, 32'h0, 32'h0},                        32'h0000_BEEF, 1'b1, 1'b0, 32'h0000_BEEF, 4'b0000};
    vecs[4] = '{2, 2'b10, 32'h200, 4'b0001, 4'b1011, {32'h33, 32'h22, 32'hB1, 32'hA0},                     32'hFFFF_FFFF, 1'b1, 1'b1, 32'hA0,        4'b0100};
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    repeat (2) tick();
    check("rst_grant", grant_a, 4'b0000);
    check("rst_op", bus_op_a, 2'b11);
    check("rst_addr", bus_addr_a, 32'h0);
    check("rst_data", bus_data_a, 32'h0);
    check("rst_hit", cache_hit_a, 4'b0000);
    check("rst_mem_req", mem_req_a, 1'b0);
    check("rst_mem_we", mem_we_a, 1'b0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Round-robin with all four cores requesting continuously.
    reset_pulse();
    req_a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int w;
      w = i % 4;
      tick();
      check("rr_grant", grant_a, rr_exp[i]);
      core_op_a[w*2 +: 2]    = 2'b01;
      core_addr_a[w*32 +: 32] = 32'h300 + 32'(i);
      tick();
      core_op_a = '1;
      check("rr_upgr", bus_op_a, 2'b01);
      tick();
      check("rr_no_mem", mem_req_a, 1'b0);
      req_a[w] = 1'b0;
      tick();
      check("rr_gap", grant_a, 4'b0000);
      if (i == 4) req_a = '0;
      else req_a[w] = 1'b1;
    end
    tick();

    // Reset asserted while a memory read is outstanding.
    req_a = 4'b0100;
    tick();
    core_op_a[4 +: 2]    = 2'b00;
    core_addr_a[64 +: 32] = 32'h44;
    tick();
    core_op_a = '1;
    tick();
    check("mid_mem_req", mem_req_a, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_grant", grant_a, 4'b0000);
    check("arst_op", bus_op_a, 2'b11);
    check("arst_addr", bus_addr_a, 32'h0);
    check("arst_mem_req", mem_req_a, 1'b0);
    check("arst_mem_addr", mem_addr_a, 32'h0);
    check("arst_mem_wdata", mem_wdata_a, 32'h0);
    req_a = 4'b0101;
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_grant", grant_a, 4'b0001);
    check("post_rst_mem", mem_req_a, 1'b0);
    req_a = '0;

    // Three-cycle snoop window; the other core hits only in the last cycle.
    req_b = 2'b01;
    tick();
    check("b_grant", grant_b, 2'b01);
    core_op_b[0 +: 2]    = 2'b00;
    core_addr_b[0 +: 32] = 32'h1234;
    tick();
    core_op_b = '1;
    check("b_bcast", bus_op_b, 2'b00);
    tick();
    check("b_op_idle", bus_op_b, 2'b11);
    check("b_hit_c1", cache_hit_b, 2'b00);
    check("b_no_mem_c1", mem_req_b, 1'b0);
    tick();
    check("b_no_mem_c2", mem_req_b, 1'b0);
    hit_b = 2'b10;
    tick();
    hit_b = 2'b00;
    check("b_hit_c3", cache_hit_b, 2'b01);
    check("b_mem_req", mem_req_b, 1'b1);
    check("b_mem_addr", mem_addr_b, 32'h1234);
    tick();
    check("b_hit_held", cache_hit_b, 2'b01);
    mem_ack_b   = 1'b1;
    mem_rdata_b = 32'hCAFE;
    tick();
    mem_ack_b   = 1'b0;
    check("b_rdata", bus_data_b, 32'hCAFE);
    check("b_hit_release", cache_hit_b, 2'b01);
    req_b = 2'b00;
    tick();
    check("b_hit_clear", cache_hit_b, 2'b00);
    check("b_grant_off", grant_b, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
